step_motor_sequencer: RTL and testbench

//  Command-driven phase sequencer for one bipolar stepper channel. It generates the
//  AX/AY/BX/BY coil pattern consumed by the port-level step_motor_driver pin mapping.
//  It accepts a move command (direction, step count, step period, full/half mode),

---
 rtl/step_motor_sequencer_if.sv | 18 +
 rtl/step_motor_sequencer.sv | 123 ++++++++++++
 tb/tb_step_motor_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/step_motor_sequencer_if.sv
// Move-command handshake for one stepper channel: the register block drives the
// command, the sequencer returns ready while it is idle.
interface step_motor_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 24
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic             cmd_half;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_period;

  modport master (output cmd_valid, cmd_dir, cmd_half, cmd_steps, cmd_period,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_dir, cmd_half, cmd_steps, cmd_period,
                  output cmd_ready);
endinterface

// File: rtl/step_motor_sequencer.sv
// Bipolar stepper phase sequencer: accepts a move command, issues timed phase
// steps on AX/AY/BX/BY and tracks signed absolute position.
module step_motor_sequencer #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 24,
  parameter int POS_W = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  step_motor_sequencer_if.slave   cmd,
  input  logic                    abort,
  input  logic                    hold_en,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
  output logic signed [POS_W-1:0] position,
  output logic                    AX,
  output logic                    AY,
  output logic                    BX,
  output logic                    BY
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic             dir;
    logic             half;
    logic [DIV_W-1:0] period_m1;
  } move_t;

  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  state_t           state, state_nx;
  move_t            mv;
  logic [CNT_W-1:0] remaining;
  logic [DIV_W-1:0] timer;
  logic [2:0]       idx, idx_nx, inc;
  logic             accept, step_evt, step_go, last_step;

  function automatic logic [3:0] phase(input logic [2:0] i);
    case (i)
      3'd0:    phase = 4'b1000;
      3'd1:    phase = 4'b1010;
      3'd2:    phase = 4'b0010;
      3'd3:    phase = 4'b0110;
      3'd4:    phase = 4'b0100;
      3'd5:    phase = 4'b0101;
      3'd6:    phase = 4'b0001;
      default: phase = 4'b1001;
    endcase
  endfunction

  assign accept    = cmd.cmd_valid & cmd.cmd_ready;
  assign step_evt  = (state == RUN) && (timer == mv.period_m1);
  // abort has priority over a coincident step event
  assign step_go   = step_evt && !abort;
  assign last_step = (remaining == CNT_W'(1));
  assign inc       = mv.half ? 3'd1 : 3'd2;
  assign idx_nx    = !step_go ? idx : (mv.dir ? idx + inc : idx - inc);

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && cmd.cmd_steps != '0) state_nx = RUN;
      RUN:     if (abort || (step_evt && last_step)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy          = (state == RUN);
    cmd.cmd_ready = (state == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mv        <= '0;
      remaining <= '0;
      timer     <= '0;
      idx       <= '0;
      position  <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      {AX, AY, BX, BY} <= 4'b0000;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mv.dir       <= cmd.cmd_dir;
        mv.half      <= cmd.cmd_half;
        mv.period_m1 <= (cmd.cmd_period == '0) ? '0 : cmd.cmd_period - DIV_W'(1);
        remaining    <= cmd.cmd_steps;
        timer        <= '0;
        aborted      <= 1'b0;
        if (cmd.cmd_steps == '0) done <= 1'b1;
      end else if (state == RUN) begin
        if (abort) begin
          done    <= 1'b1;
          aborted <= 1'b1;
          timer   <= '0;
        end else if (step_evt) begin
          timer     <= '0;
          idx       <= idx_nx;
          position  <= mv.dir ? position + POS_ONE : position - POS_ONE;
          remaining <= remaining - CNT_W'(1);
          if (last_step) done <= 1'b1;
        end else begin
          timer <= timer + DIV_W'(1);
        end
      end
      // final step pattern is always shown for at least the done cycle
      {AX, AY, BX, BY} <= (state_nx == RUN || step_go || hold_en) ? phase(idx_nx) : 4'b0000;
    end
  end

endmodule

// File: tb/tb_step_motor_sequencer.sv
// Directed bench for step_motor_sequencer: half/full-step moves, zero-step,
// abort timing, busy-time command rejection, hold and asynchronous reset.
module tb_step_motor_sequencer;
  logic               clk = 1'b0;
  logic               reset_n;
  logic               abort, hold_en;
  logic               busy, done, aborted;
  logic signed [31:0] position;
  logic               AX, AY, BX, BY;
  logic [3:0]         coils;
  int                 nchecks = 0;
  int                 nerrs   = 0;
  int                 busy_cnt;
  logic [3:0]         tbl [8] = '{4'b1000, 4'b1010, 4'b0010, 4'b0110,
                                  4'b0100, 4'b0101, 4'b0001, 4'b1001};

  step_motor_sequencer_if #(.CNT_W(16), .DIV_W(24)) cif ();

  step_motor_sequencer #(.CNT_W(16), .DIV_W(24), .POS_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .cmd(cif.slave), .abort(abort), .hold_en(hold_en),
    .busy(busy), .done(done), .aborted(aborted), .position(position),
    .AX(AX), .AY(AY), .BX(BX), .BY(BY));

  assign coils = {AX, AY, BX, BY};
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic dir, input logic half, input logic [15:0] steps,
                      input logic [23:0] period);
    cif.cmd_valid = 1'b1; cif.cmd_dir = dir; cif.cmd_half = half;
    cif.cmd_steps = steps; cif.cmd_period = period;
    cyc();
    cif.cmd_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; abort = 1'b0; hold_en = 1'b1;
    cif.cmd_valid = 1'b0; cif.cmd_dir = 1'b0; cif.cmd_half = 1'b0;
    cif.cmd_steps = '0; cif.cmd_period = '0;
    cyc(); cyc();
    check("rst_coils", coils, 4'b0000);
    check("rst_pos", position, 0);
    check("rst_flags", {busy, done, aborted}, 3'b000);
    check("rst_ready", cif.cmd_ready, 1'b1);
    reset_n = 1'b1;
    cyc();

    // 1: half-step forward, 8 steps every 4 cycles
    send(1'b1, 1'b1, 16'd8, 24'd4);
    check("t1_busy0", {busy, cif.cmd_ready}, 2'b10);
    check("t1_pat0", coils, 4'b1000);
    for (int k = 1; k <= 32; k++) begin
      cyc();
      check("t1_pat", coils, tbl[(k / 4) % 8]);
      check("t1_pos", position, 64'(k / 4));
      check("t1_done", done, (k == 32));
      check("t1_busy", busy, (k < 32));
    end

    // zero period behaves as one: single step lands on the next edge
    send(1'b1, 1'b1, 16'd1, 24'd0);
    cyc();
    check("p0_pat", coils, 4'b1010);
    check("p0_pos", position, 9);
    check("p0_done", {done, busy}, 2'b10);

    // 2: full-step reverse from idx 1, late command changes ignored
    send(1'b0, 1'b0, 16'd3, 24'd2);
    cif.cmd_dir = 1'b1; cif.cmd_half = 1'b1;
    busy_cnt = busy ? 1 : 0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (busy) busy_cnt++;
      if (k == 2) check("t2_pat1", coils, 4'b1001);
      if (k == 4) check("t2_pat2", coils, 4'b0101);
    end
    check("t2_pat3", coils, 4'b0110);
    check("t2_pos", position, 6);
    check("t2_done", done, 1'b1);
    check("t2_busy_cycles", busy_cnt, 6);

    // 3: zero-step command
    cyc();
    send(1'b1, 1'b1, 16'd0, 24'd5);
    check("t3_done", {done, busy}, 2'b10);
    check("t3_state", {coils, position[7:0]}, {4'b0110, 8'd6});
    cyc();
    check("t3_done_pulse", {done, busy}, 2'b00);

    // 4: abort at cycle 25 of a 100-step move
    send(1'b1, 1'b1, 16'd100, 24'd10);
    for (int k = 1; k <= 24; k++) cyc();
    check("t4_pre_abort", {busy, done}, 2'b10);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("t4_flags", {busy, done, aborted}, 3'b011);
    check("t4_pos", position, 8);
    check("t4_pat", coils, 4'b0101);
    cyc();
    check("t4_sticky", {done, aborted}, 2'b01);
    send(1'b0, 1'b0, 16'd0, 24'd1);
    check("t4_clear", aborted, 1'b0);

    // 5: abort coincident with the 3rd step, busy-time command ignored
    cyc();
    send(1'b1, 1'b0, 16'd5, 24'd3);
    cyc(); cyc(); cyc();
    check("t5_step1", {coils, position[7:0]}, {4'b1001, 8'd9});
    send(1'b0, 1'b1, 16'd0, 24'd1);
    check("t5_ignored", {busy, done, cif.cmd_ready}, 3'b100);
    check("t5_ign_state", {coils, position[7:0]}, {4'b1001, 8'd9});
    cyc(); cyc(); cyc(); cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("t5_pos", position, 10);
    check("t5_pat", coils, 4'b1010);
    check("t5_flags", {busy, done, aborted}, 3'b011);

    // 6: hold, release hold, reset mid-move
    send(1'b1, 1'b1, 16'd1, 24'd2);
    cyc(); cyc();
    check("t6_end", {coils, done, position[7:0]}, {4'b0010, 1'b1, 8'd11});
    cyc();
    check("t6_hold", coils, 4'b0010);
    hold_en = 1'b0;
    check("t6_hold_lag", coils, 4'b0010);
    cyc();
    check("t6_release", coils, 4'b0000);
    send(1'b1, 1'b1, 16'd10, 24'd2);
    cyc(); cyc(); cyc();
    check("t6_moving", {busy, coils}, {1'b1, 4'b0110});
    #3 reset_n = 1'b0;
    #1;
    check("t6_rst_coils", coils, 4'b0000);
    check("t6_rst_pos", position, 0);
    check("t6_rst_flags", {busy, done, aborted, cif.cmd_ready}, 4'b0001);
    reset_n = 1'b1;
    cyc();
    check("t6_after_rst", {busy, coils}, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end
endmodule
